// File: rtl/ffi_audio_pkg.sv
// Shared types and helpers for the ffi audio output path.
package ffi_audio_pkg;

    localparam int PCM_W = 16;

    typedef struct packed {
        logic signed [PCM_W-1:0] l;
        logic signed [PCM_W-1:0] r;
    } pcm_pair_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ffi_sample_fifo.sv
// Small synchronous FIFO of L/R sample pairs with first-word-fall-through read data.
module ffi_sample_fifo
    import ffi_audio_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk50,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  pcm_pair_t        wr_data,
    output pcm_pair_t        rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    pcm_pair_t mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ffi_i2s_tx.sv
// Stereo I2S transmitter (codec in slave mode): BCLK/LRCK generation, sample FIFO,
// MSB-first serialiser with one-BCLK delay, and saturating underrun/overflow counters.
module ffi_i2s_tx
    import ffi_audio_pkg::*;
#(
    parameter int BCLK_HALF  = 48,
    parameter int SLOT_BITS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [PCM_W-1:0]  l_data,
    input  logic [PCM_W-1:0]  r_data,
    input  logic              l_valid,
    input  logic              r_valid,
    output logic              l_ready,
    output logic              r_ready,
    output logic              aud_bclk,
    output logic              aud_daclrck,
    output logic              aud_dacdat,
    input  logic              clr_counts,
    output logic [15:0]       underrun_cnt,
    output logic [15:0]       overflow_cnt
);

    localparam int DIV_W = $clog2(BCLK_HALF);
    localparam int IDX_W = $clog2(2 * SLOT_BITS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(PCM_W);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * SLOT_BITS - 1);
    localparam logic [IDX_W-1:0] SLOT_LEN = IDX_W'(SLOT_BITS);
    localparam logic [IDX_W-1:0] PCM_LEN  = IDX_W'(PCM_W);

    logic [DIV_W-1:0] div;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] bit_idx_nxt;
    logic [IDX_W-1:0] slot_pos;
    logic [PCM_W-1:0] chan;
    logic             bclk;
    logic             lrck;
    logic             dacdat;
    logic             lrck_nxt;
    logic             dacdat_nxt;
    logic             ready;
    logic             bclk_fall;
    logic             frame_start;
    pcm_pair_t        shadow;
    pcm_pair_t        fifo_rd;
    pcm_pair_t        fifo_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_nxt;
    logic             push;
    logic             pop;
    logic             underrun_inc;
    logic             overflow_inc;

    assign bclk_fall    = (div == DIV_TC) && bclk;
    assign frame_start  = bclk_fall && (bit_idx == IDX_LAST);
    assign bit_idx_nxt  = (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
    assign push         = enable && l_valid && r_valid && ready && !fifo_full;
    assign pop          = enable && frame_start && !fifo_empty;
    assign underrun_inc = enable && frame_start && fifo_empty;
    assign overflow_inc = enable && l_valid && r_valid && !ready;
    assign fifo_wr      = '{l: l_data, r: r_data};

    ffi_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk50   (clk50),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (!enable),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Slot position 0 is the I2S delay bit; the sample occupies positions 1..PCM_W.
    always_comb begin
        lrck_nxt   = (bit_idx_nxt >= SLOT_LEN);
        slot_pos   = lrck_nxt ? bit_idx_nxt - SLOT_LEN : bit_idx_nxt;
        chan       = lrck_nxt ? shadow.r : shadow.l;
        dacdat_nxt = 1'b0;
        if (slot_pos != '0 && slot_pos <= PCM_LEN) dacdat_nxt = chan[BIT_W'(PCM_LEN - slot_pos)];
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            bclk    <= 1'b0;
            bit_idx <= '0;
            lrck    <= 1'b0;
            dacdat  <= 1'b0;
        end else if (!enable) begin
            div     <= '0;
            bclk    <= 1'b0;
            bit_idx <= '0;
            lrck    <= 1'b0;
            dacdat  <= 1'b0;
        end else begin
            if (div == DIV_TC) begin
                div  <= '0;
                bclk <= ~bclk;
            end else begin
                div  <= div + 1'b1;
            end
            if (bclk_fall) begin
                bit_idx <= bit_idx_nxt;
                lrck    <= lrck_nxt;
                dacdat  <= dacdat_nxt;
            end
        end
    end

    // Ready looks at the post-update occupancy so a full FIFO is never offered.
    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)      count_nxt = fifo_count + 1'b1;
        else if (!push && pop) count_nxt = fifo_count - 1'b1;
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            ready  <= 1'b0;
            shadow <= '0;
        end else begin
            ready <= enable && (count_nxt != CNT_W'(FIFO_DEPTH));
            if (pop) shadow <= fifo_rd;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else if (clr_counts) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (underrun_inc) underrun_cnt <= sat_inc16(underrun_cnt);
            if (overflow_inc) overflow_cnt <= sat_inc16(overflow_cnt);
        end
    end

    assign l_ready     = ready;
    assign r_ready     = ready;
    assign aud_bclk    = bclk;
    assign aud_daclrck = lrck;
    assign aud_dacdat  = dacdat;

endmodule

// File: tb/tb_ffi_i2s_tx.sv
// Self-checking bench for ffi_i2s_tx: a time-based reference model of the I2S frame
// plus a queue-based FIFO model, compared against the DUT every clk50 cycle.
module tb_ffi_i2s_tx;

    localparam int BCLK_HALF  = 48;
    localparam int SLOT_BITS  = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 2 * BCLK_HALF * 2 * SLOT_BITS;

    logic        clk50 = 1'b0;
    logic        reset_n, enable, l_valid, r_valid, clr_counts;
    logic [15:0] l_data, r_data;
    logic        l_ready, r_ready, aud_bclk, aud_daclrck, aud_dacdat;
    logic [15:0] underrun_cnt, overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: t = clk50 cycles since the serial engine (re)started
    int          t;
    logic [31:0] q[$];
    logic        m_ready;
    logic [31:0] m_shadow;
    int          m_und, m_ovf;
    bit          fs_event;

    logic [63:0] sh64, lr64;
    logic        prev_bclk;
    int          cyc, last_rise, bclk_period;

    ffi_i2s_tx #(.BCLK_HALF(BCLK_HALF), .SLOT_BITS(SLOT_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk50        (clk50),
        .reset_n      (reset_n),
        .enable       (enable),
        .l_data       (l_data),
        .r_data       (r_data),
        .l_valid      (l_valid),
        .r_valid      (r_valid),
        .l_ready      (l_ready),
        .r_ready      (r_ready),
        .aud_bclk     (aud_bclk),
        .aud_daclrck  (aud_daclrck),
        .aud_dacdat   (aud_dacdat),
        .clr_counts   (clr_counts),
        .underrun_cnt (underrun_cnt),
        .overflow_cnt (overflow_cnt)
    );

    always #10 clk50 = ~clk50;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_idx();
        return (t / (2 * BCLK_HALF)) % (2 * SLOT_BITS);
    endfunction

    function automatic logic exp_bclk();
        return ((t / BCLK_HALF) % 2) == 1;
    endfunction

    function automatic logic exp_lrck();
        return exp_idx() >= SLOT_BITS;
    endfunction

    function automatic logic exp_dat();
        int k;
        logic [15:0] chan;
        k    = exp_idx() % SLOT_BITS;
        chan = exp_lrck() ? m_shadow[15:0] : m_shadow[31:16];
        if (k >= 1 && k <= 16) return chan[16-k];
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit push, frame, und_inc, ovf_inc;
        fs_event = 0;
        if (!reset_n) begin
            t = 0; q.delete(); m_ready = 0; m_shadow = '0; m_und = 0; m_ovf = 0;
            return;
        end
        push = 0; frame = 0; und_inc = 0;
        ovf_inc = enable && l_valid && r_valid && !m_ready;
        if (enable) begin
            t++;
            frame = (t % FRAME) == 0;
            push  = l_valid && r_valid && m_ready;
        end
        if (frame) begin
            fs_event = 1;
            if (q.size() > 0) m_shadow = q.pop_front();
            else und_inc = 1;
        end
        if (!enable) begin
            t = 0;
            q.delete();
        end else if (push) begin
            q.push_back({l_data, r_data});
        end
        if (clr_counts) begin
            m_und = 0; m_ovf = 0;
        end else begin
            if (und_inc && m_und < 65535) m_und++;
            if (ovf_inc && m_ovf < 65535) m_ovf++;
        end
        m_ready = enable && (q.size() < FIFO_DEPTH);
    endtask

    task automatic tick();
        @(posedge clk50);
        model_edge();
        @(negedge clk50);
        cyc++;
        check_eq("l_ready", l_ready, m_ready);
        check_eq("r_ready", r_ready, m_ready);
        check_eq("bclk", aud_bclk, exp_bclk());
        check_eq("lrck", aud_daclrck, exp_lrck());
        check_eq("dacdat", aud_dacdat, exp_dat());
        check_eq("underrun_cnt", underrun_cnt, m_und);
        check_eq("overflow_cnt", overflow_cnt, m_ovf);
        if (!prev_bclk && aud_bclk) begin
            sh64 = {sh64[62:0], aud_dacdat};
            lr64 = {lr64[62:0], aud_daclrck};
            if (last_rise >= 0) bclk_period = cyc - last_rise;
            last_rise = cyc;
        end
        prev_bclk = aud_bclk;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        l_valid = 1; r_valid = 1; l_data = l; r_data = r;
        tick();
        l_valid = 0; r_valid = 0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!fs_event && n < FRAME + 10);
    endtask

    task automatic run_to_pre_frame();
        int n = 0;
        while ((t % FRAME) != FRAME - 1 && n < FRAME + 10) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_bclk_rise(output int n);
        n = 0;
        while (!aud_bclk && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, r;
        reset_n = 0; enable = 1; l_valid = 0; r_valid = 0; clr_counts = 0;
        l_data = '0; r_data = '0;
        t = 0; m_ready = 0; m_shadow = '0; m_und = 0; m_ovf = 0; fs_event = 0;
        sh64 = '0; lr64 = '0; prev_bclk = 0; cyc = 0; last_rise = -1; bclk_period = 0;

        // reset, first ready, first BCLK rise
        repeat (5) tick();
        reset_n = 1;
        tick();
        check_eq("ready_first_cycle", l_ready, 1);
        n = 1;
        while (!aud_bclk && n < 200) begin
            tick();
            n++;
        end
        check_eq("first_bclk_rise_cycle", n, 48);

        // one pair, then a lone left-valid that must be ignored
        push_pair(16'h8001, 16'h7FFE);
        l_valid = 1; l_data = 16'(($urandom));
        tick();
        l_valid = 0;
        wait_frame();
        repeat (FRAME) tick();
        check_eq("frame1_data", sh64, {32'h4000_8000, 32'h3FFF_0000});
        check_eq("frame1_lrck", lr64, {32'h0000_0000, 32'hFFFF_FFFF});
        check_eq("bclk_period", bclk_period, 96);
        check_eq("single_valid_no_push", underrun_cnt, 1);

        // starvation: shadow pair repeats, underruns accumulate
        repeat (2 * FRAME) tick();
        check_eq("underrun_after_3", underrun_cnt, 3);
        check_eq("repeat_frame_data", sh64, {32'h4000_8000, 32'h3FFF_0000});

        // fill the FIFO, then overflow
        for (int i = 0; i < 4; i++) push_pair(16'($urandom), 16'($urandom));
        check_eq("full_ready_low", l_ready, 0);
        push_pair(16'($urandom), 16'($urandom));
        check_eq("overflow_one", overflow_cnt, 1);
        r_valid = 1;
        tick();
        r_valid = 0;
        check_eq("single_valid_no_ovf", overflow_cnt, 1);

        // push coinciding with a frame pop while holding 3 entries
        wait_frame();
        run_to_pre_frame();
        push_pair(16'($urandom), 16'($urandom));
        check_eq("push_pop_ready", l_ready, 1);
        push_pair(16'($urandom), 16'($urandom));
        check_eq("refill_full", l_ready, 0);

        // disable mid-frame at bit 20, then re-enable
        n = 0;
        while (exp_idx() != 20 && n < FRAME) begin
            tick();
            n++;
        end
        enable = 0;
        tick();
        check_eq("dis_bclk", aud_bclk, 0);
        check_eq("dis_lrck", aud_daclrck, 0);
        check_eq("dis_ready", l_ready, 0);
        repeat (10) tick();
        enable = 1;
        tick();
        check_eq("reen_ready_flushed", l_ready, 1);
        wait_bclk_rise(n);
        check_eq("reen_bclk_rise_found", aud_bclk, 1);
        check_eq("reen_first_bit", aud_dacdat, 0);
        check_eq("reen_first_lrck", aud_daclrck, 0);

        // clear coinciding with an underrun
        run_to_pre_frame();
        clr_counts = 1;
        tick();
        clr_counts = 0;
        check_eq("clr_vs_underrun", underrun_cnt, 0);
        check_eq("clr_overflow", overflow_cnt, 0);

        // randomized traffic
        for (int i = 0; i < 12000; i++) begin
            r = $urandom_range(0, 99);
            l_valid    = (r < 3) || (r == 3);
            r_valid    = (r < 3) || (r == 4);
            l_data     = 16'($urandom);
            r_data     = 16'($urandom);
            clr_counts = ($urandom_range(0, 2999) == 0);
            tick();
        end
        l_valid = 0; r_valid = 0; clr_counts = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
